pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_entry.sv | 33 +++
 rtl/pipe_skid_reg.sv | 129 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode skid register: occupancy states
// and the NOP instruction that is presented when no entry is valid.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot (instr, pc, pc_plus4) with load enable and synchronous clear.
module pipe_entry #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] d_instr,
   input  logic [DATA_WIDTH-1:0] d_pc,
   input  logic [DATA_WIDTH-1:0] d_pc_plus4,
   output logic [DATA_WIDTH-1:0] q_instr,
   output logic [DATA_WIDTH-1:0] q_pc,
   output logic [DATA_WIDTH-1:0] q_pc_plus4
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_instr    <= '0;
         q_pc       <= '0;
         q_pc_plus4 <= '0;
      end else if (clear) begin
         q_instr    <= '0;
         q_pc       <= '0;
         q_pc_plus4 <= '0;
      end else if (load) begin
         q_instr    <= d_instr;
         q_pc       <= d_pc;
         q_pc_plus4 <= d_pc_plus4;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry fetch/decode skid buffer; in_ready depends on registered state only.
// Define PIPE_SKID_PERF_EN to add saturating stall/flush performance counters.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_instr,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [DATA_WIDTH-1:0] in_pc_plus4,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_pc_plus4
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]  perf_stall_cnt,
   output logic [CNT_WIDTH-1:0]  perf_flush_cnt
`endif
);

   localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);

   state_t state, state_next;
   logic   accept, consume;
   logic   main_load, main_from_skid, skid_load, clear_all;

   logic [DATA_WIDTH-1:0] main_instr, main_pc, main_pc_plus4;
   logic [DATA_WIDTH-1:0] skid_instr, skid_pc, skid_pc_plus4;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_next;
   end

   always_comb begin
      state_next     = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      clear_all      = 1'b0;
      if (flush) begin
         state_next = EMPTY;
         clear_all  = 1'b1;
      end else begin
         unique case (state)
            EMPTY: if (accept) begin
               state_next = BUSY;
               main_load  = 1'b1;
            end
            BUSY: begin
               if (accept && consume) begin
                  main_load = 1'b1;
               end else if (consume) begin
                  state_next = EMPTY;
               end else if (accept) begin
                  state_next = FULL;
                  skid_load  = 1'b1;
               end
            end
            FULL: if (consume) begin
               // The overflow entry moves up so the older-first order is kept.
               state_next     = BUSY;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   pipe_entry #(.DATA_WIDTH(DATA_WIDTH)) u_main (
      .clk        (clk),
      .rst        (rst),
      .load       (main_load),
      .clear      (clear_all),
      .d_instr    (main_from_skid ? skid_instr    : in_instr),
      .d_pc       (main_from_skid ? skid_pc       : in_pc),
      .d_pc_plus4 (main_from_skid ? skid_pc_plus4 : in_pc_plus4),
      .q_instr    (main_instr),
      .q_pc       (main_pc),
      .q_pc_plus4 (main_pc_plus4)
   );

   pipe_entry #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load),
      .clear      (clear_all),
      .d_instr    (in_instr),
      .d_pc       (in_pc),
      .d_pc_plus4 (in_pc_plus4),
      .q_instr    (skid_instr),
      .q_pc       (skid_pc),
      .q_pc_plus4 (skid_pc_plus4)
   );

   assign out_instr    = out_valid ? main_instr    : NOP_W;
   assign out_pc       = out_valid ? main_pc       : '0;
   assign out_pc_plus4 = out_valid ? main_pc_plus4 : '0;

`ifdef PIPE_SKID_PERF_EN
   // Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && !(&perf_stall_cnt))
            perf_stall_cnt <= perf_stall_cnt + CNT_WIDTH'(1);
         if (flush && (state != EMPTY) && !(&perf_flush_cnt))
            perf_flush_cnt <= perf_flush_cnt + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic, checked
// against a queue-based occupancy model (counters checked when PIPE_SKID_PERF_EN).
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_pc_plus4;
   logic        in_ready, out_valid;
   logic [31:0] out_instr, out_pc, out_pc_plus4;
`ifdef PIPE_SKID_PERF_EN
   logic [15:0] perf_stall_cnt, perf_flush_cnt;
   logic        in_ready2, out_valid2;
   logic [31:0] out_instr2, out_pc2, out_pc_plus4_2;
   logic [1:0]  perf_stall_cnt2, perf_flush_cnt2;
`endif

   always #5 clk = ~clk;

   pipe_skid_reg #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .in_pc_plus4  (in_pc_plus4),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_pc_plus4 (out_pc_plus4)
`ifdef PIPE_SKID_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

`ifdef PIPE_SKID_PERF_EN
   // Narrow-counter copy driven identically, used to observe saturation.
   pipe_skid_reg #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut2 (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready2),
      .in_instr       (in_instr),
      .in_pc          (in_pc),
      .in_pc_plus4    (in_pc_plus4),
      .out_valid      (out_valid2),
      .out_ready      (out_ready),
      .out_instr      (out_instr2),
      .out_pc         (out_pc2),
      .out_pc_plus4   (out_pc_plus4_2),
      .perf_stall_cnt (perf_stall_cnt2),
      .perf_flush_cnt (perf_flush_cnt2)
   );
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } ent_t;

   ent_t q[$];
   int   stall_m = 0;
   int   flush_m = 0;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      stall_m = 0;
      flush_m = 0;
   endtask

   // Called at each rising edge with the inputs that the design sampled.
   task automatic model_edge();
      bit acc;
      bit con;
      if (rst) begin
         model_clear();
      end else begin
         if (q.size() > 0 && !out_ready) stall_m++;
         if (flush) begin
            if (q.size() > 0) flush_m++;
            q.delete();
         end else begin
            acc = in_valid && (q.size() < 2);
            con = (q.size() > 0) && out_ready;
            if (con) void'(q.pop_front());
            if (acc) q.push_back('{in_instr, in_pc, in_pc_plus4});
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] e_instr, e_pc, e_pc4;
      if (q.size() > 0) begin
         e_instr = q[0].instr;
         e_pc    = q[0].pc;
         e_pc4   = q[0].pc4;
      end else begin
         e_instr = 32'h0000_0013;
         e_pc    = 32'h0;
         e_pc4   = 32'h0;
      end
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
      chk({tag, ".out_instr"}, out_instr, e_instr);
      chk({tag, ".out_pc"}, out_pc, e_pc);
      chk({tag, ".out_pc_plus4"}, out_pc_plus4, e_pc4);
`ifdef PIPE_SKID_PERF_EN
      chk({tag, ".stall_cnt"}, 32'(perf_stall_cnt), (stall_m > 65535) ? 32'd65535 : 32'(stall_m));
      chk({tag, ".flush_cnt"}, 32'(perf_flush_cnt), (flush_m > 65535) ? 32'd65535 : 32'(flush_m));
      chk({tag, ".stall_cnt_w2"}, 32'(perf_stall_cnt2), (stall_m > 3) ? 32'd3 : 32'(stall_m));
      chk({tag, ".flush_cnt_w2"}, 32'(perf_flush_cnt2), (flush_m > 3) ? 32'd3 : 32'(flush_m));
`endif
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   task automatic set_in(input logic v, input logic [31:0] pc);
      in_valid    = v;
      in_pc       = pc;
      in_pc_plus4 = pc + 32'd4;
      in_instr    = $urandom;
   endtask

   // Asserts reset between edges, checks it takes effect at once, releases after an edge.
   task automatic pulse_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_outputs(tag);
      chk({tag, ".vld0"}, 32'(out_valid), 32'd0);
      chk({tag, ".rdy1"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      set_in(1'b0, 32'h0);
      #2;
      model_clear();
      check_outputs("reset");
      chk("reset.nop", out_instr, 32'h0000_0013);
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("idle0");
      step("idle1");

      // Streaming
      out_ready = 1'b1;
      set_in(1'b1, 32'h0);
      step("stream0");
      chk("stream.pc0", out_pc, 32'h0);
      set_in(1'b1, 32'h4);
      step("stream1");
      chk("stream.pc4", out_pc, 32'h4);
      set_in(1'b1, 32'h8);
      step("stream2");
      chk("stream.pc8", out_pc, 32'h8);
      set_in(1'b0, 32'h0);
      step("stream_drain");

      // Backpressure
      out_ready = 1'b0;
      set_in(1'b1, 32'h10);
      step("bp0");
      set_in(1'b1, 32'h14);
      step("bp1");
      chk("bp.full_ready", 32'(in_ready), 32'd0);
      chk("bp.hold10", out_pc, 32'h10);
      set_in(1'b1, 32'h18);
      step("bp_refused");
      chk("bp.still10", out_pc, 32'h10);
      set_in(1'b0, 32'h0);
      out_ready = 1'b1;
      #1;
      chk("bp.first10", out_pc, 32'h10);
      step("bp_drain0");
      chk("bp.then14", out_pc, 32'h14);
      step("bp_drain1");

      // Flush while FULL with an incoming entry
      out_ready = 1'b0;
      set_in(1'b1, 32'h30);
      step("fl0");
      set_in(1'b1, 32'h34);
      step("fl1");
      set_in(1'b1, 32'h20);
      flush = 1'b1;
      step("flush");
      flush = 1'b0;
      chk("flush.vld", 32'(out_valid), 32'd0);
      chk("flush.nop", out_instr, 32'h0000_0013);
      set_in(1'b0, 32'h0);
      out_ready = 1'b1;
      step("flush_after");
      chk("flush.no20", 32'(out_valid), 32'd0);

      // Reset mid-stream while BUSY
      out_ready = 1'b0;
      set_in(1'b1, 32'h40);
      step("busy");
      set_in(1'b0, 32'h0);
      pulse_reset("midrst");
      step("post_rst");
      chk("post_rst.vld", 32'(out_valid), 32'd0);

      // Counters: 3 stalls then a flush while BUSY
      pulse_reset("perf_rst");
      out_ready = 1'b0;
      set_in(1'b1, 32'h50);
      step("perf_acc");
      set_in(1'b0, 32'h0);
      repeat (3) step("perf_stall");
      out_ready = 1'b1;
      flush = 1'b1;
      step("perf_flush");
      flush = 1'b0;
`ifdef PIPE_SKID_PERF_EN
      chk("perf.stall3", 32'(perf_stall_cnt), 32'd3);
      chk("perf.flush1", 32'(perf_flush_cnt), 32'd1);
`endif

      // Saturation of the narrow copy
      pulse_reset("sat_rst");
      out_ready = 1'b0;
      set_in(1'b1, 32'h60);
      step("sat_acc");
      set_in(1'b0, 32'h0);
      repeat (5) step("sat_stall");
`ifdef PIPE_SKID_PERF_EN
      chk("sat.w2", 32'(perf_stall_cnt2), 32'd3);
      chk("sat.w16", 32'(perf_stall_cnt), 32'd5);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         set_in($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3fff_ffff), 2'b00});
         step("rand");
      end
      flush = 1'b0;
      set_in(1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
